// File: rtl/subleq_regsw_seq_pkg.sv
// rtl/subleq_regsw_seq_pkg.sv - shared state encodings and switch direction constants for the SUBLEQ sequencer
package subleq_regsw_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_TURN = 3'd3,
    ST_WR_B = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  localparam int PC_STEP_DEF = 3;

endpackage

// File: rtl/subleq_regsw_seq_alu.sv
// rtl/subleq_regsw_seq_alu.sv - combinational SUBLEQ difference, branch decision and next PC
module subleq_regsw_seq_alu #(
  parameter int DW      = 8,
  parameter int PC_STEP = subleq_regsw_seq_pkg::PC_STEP_DEF
) (
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] pc,
  output logic [DW-1:0] diff,
  output logic          leq,
  output logic [DW-1:0] next_pc
);

  localparam logic [DW-1:0] STEP = DW'(PC_STEP);

  // result <= 0 in two's complement: sign bit set or exactly zero
  always_comb begin
    diff    = op_b - op_a;
    leq     = diff[DW-1] || (diff == '0);
    next_pc = leq ? c : (pc + STEP);
  end

endmodule

// File: rtl/subleq_regsw_seq.sv
// rtl/subleq_regsw_seq.sv - one SUBLEQ per command through the 8-entry register switch
module subleq_regsw_seq
  import subleq_regsw_seq_pkg::*;
#(
  parameter int DW      = 8,
  parameter int NREG    = 8,
  parameter int SELW    = 3,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [SELW-1:0] cmd_a,
  input  logic [SELW-1:0] cmd_b,
  input  logic [DW-1:0]   cmd_c,
  input  logic [DW-1:0]   cmd_pc,
  output logic [SELW-1:0] sw_sel,
  output logic            sw_dir,
  inout  wire  [DW-1:0]   sw_bus,
  output logic [NREG-1:0] reg_load,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_pc,
  output logic            rsp_leq,
  output logic            busy
);

  localparam logic [NREG-1:0] LOAD_ONE = NREG'(1);

  state_t          state;
  logic [SELW-1:0] b_q;
  logic [DW-1:0]   c_q;
  logic [DW-1:0]   pc_q;
  logic [DW-1:0]   op_a;
  logic [DW-1:0]   op_b;
  logic [DW-1:0]   diff_q;
  logic            leq_q;
  logic            bus_oe;

  logic [DW-1:0]   alu_diff;
  logic            alu_leq;
  logic [DW-1:0]   alu_next_pc;

  subleq_regsw_seq_alu #(
    .DW      (DW),
    .PC_STEP (PC_STEP)
  ) u_alu (
    .op_a    (op_a),
    .op_b    (op_b),
    .c       (c_q),
    .pc      (pc_q),
    .diff    (alu_diff),
    .leq     (alu_leq),
    .next_pc (alu_next_pc)
  );

  // bus_oe is only ever set together with sw_dir=DIR_WR, so the switch never sees a read-direction drive
  assign sw_bus = bus_oe ? diff_q : {DW{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sw_sel    <= '0;
      sw_dir    <= DIR_RD;
      bus_oe    <= 1'b0;
      reg_load  <= '0;
      rsp_valid <= 1'b0;
      rsp_pc    <= '0;
      rsp_leq   <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      b_q       <= '0;
      c_q       <= '0;
      pc_q      <= '0;
      op_a      <= '0;
      op_b      <= '0;
      diff_q    <= '0;
      leq_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            b_q       <= cmd_b;
            c_q       <= cmd_c;
            pc_q      <= cmd_pc;
            sw_sel    <= cmd_a;
            sw_dir    <= DIR_RD;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_RD_A;
          end
        end
        ST_RD_A: begin
          op_a   <= sw_bus;
          sw_sel <= b_q;
          state  <= ST_RD_B;
        end
        ST_RD_B: begin
          op_b   <= sw_bus;
          sw_dir <= DIR_WR;
          state  <= ST_TURN;
        end
        // turnaround cycle: direction already flipped, bus still released
        ST_TURN: begin
          diff_q   <= alu_diff;
          leq_q    <= alu_leq;
          bus_oe   <= 1'b1;
          reg_load <= LOAD_ONE << b_q;
          state    <= ST_WR_B;
        end
        ST_WR_B: begin
          bus_oe    <= 1'b0;
          reg_load  <= '0;
          sw_dir    <= DIR_RD;
          rsp_valid <= 1'b1;
          rsp_leq   <= leq_q;
          rsp_pc    <= alu_next_pc;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          bus_oe    <= 1'b0;
          reg_load  <= '0;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subleq_regsw_seq.sv
// tb/tb_subleq_regsw_seq.sv - scoreboard bench for the SUBLEQ register switch sequencer
module tb_subleq_regsw_seq;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_a;
  logic [2:0] cmd_b;
  logic [7:0] cmd_c;
  logic [7:0] cmd_pc;
  logic [2:0] sw_sel;
  logic       sw_dir;
  wire  [7:0] sw_bus;
  logic [7:0] reg_load;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_pc;
  logic       rsp_leq;
  logic       busy;

  subleq_regsw_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_c     (cmd_c),
    .cmd_pc    (cmd_pc),
    .sw_sel    (sw_sel),
    .sw_dir    (sw_dir),
    .sw_bus    (sw_bus),
    .reg_load  (reg_load),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_pc    (rsp_pc),
    .rsp_leq   (rsp_leq),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file behind the switch
  logic [7:0] regs [8];
  logic       pre_we;
  logic [2:0] pre_idx;
  logic [7:0] pre_dat;

  assign sw_bus = (sw_dir == 1'b0) ? regs[sw_sel] : 8'hzz;

  always @(posedge clk) begin
    if (pre_we) regs[pre_idx] <= pre_dat;
    for (int i = 0; i < 8; i++)
      if (reg_load[i]) regs[i] <= sw_bus;
  end

  typedef struct {
    logic [7:0] pc;
    logic       leq;
    logic [2:0] b;
    logic [7:0] val;
  } exp_t;

  exp_t       sbq [$];
  int         accq [$];
  logic [7:0] exp_regs [8];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         pulses = 0;
  logic [7:0] last_load = '0;
  logic       prev_valid = 1'b0;
  int         rr_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // monitor: protocol checks every cycle, scoreboard pop on each response handshake
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        accq.push_back(cyc + 1);
        pulses = 0;
      end
      if (reg_load != 8'h00) begin
        pulses++;
        last_load = reg_load;
        chk("load_dir", {31'd0, sw_dir}, 32'd1);
      end
      if (dut.bus_oe)
        chk("drive_only_in_write", {30'd0, sw_dir, reg_load != 8'h00}, 32'd3);
      chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~cmd_ready});
      if (rsp_valid && !prev_valid) begin
        if (accq.size() == 0) fail_now("rsp_without_accept");
        else chk("latency", cyc - accq.pop_front(), 32'd4);
      end
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          e = sbq.pop_front();
          chk("rsp_pc", {24'd0, rsp_pc}, {24'd0, e.pc});
          chk("rsp_leq", {31'd0, rsp_leq}, {31'd0, e.leq});
          chk("reg_b_written", {24'd0, regs[e.b]}, {24'd0, e.val});
          chk("load_pulses", pulses, 32'd1);
          chk("load_onehot", {24'd0, last_load}, 32'd1 << e.b);
        end
      end
      prev_valid = rsp_valid;
    end
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  task automatic preload(input logic [2:0] idx, input logic [7:0] dat);
    @(posedge clk);
    #1;
    pre_we  = 1'b1;
    pre_idx = idx;
    pre_dat = dat;
    exp_regs[idx] = dat;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [7:0] c,
                       input logic [7:0] pc, input bit expect_rsp);
    exp_t e;
    int   d;
    bit   ok;
    d = (int'(exp_regs[b]) - int'(exp_regs[a]) + 256) % 256;
    e.leq = ($signed(8'(d)) <= 0);
    e.pc  = e.leq ? c : 8'((int'(pc) + 3) % 256);
    e.b   = b;
    e.val = 8'(d);
    if (expect_rsp) begin
      sbq.push_back(e);
      exp_regs[b] = 8'(d);
    end
    @(posedge clk);
    #1;
    cmd_a = a;
    cmd_b = b;
    cmd_c = c;
    cmd_pc = pc;
    cmd_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("drain_timeout");
  endtask

  initial begin
    logic [7:0] hold_pc;
    logic       hold_leq;
    bit         ok;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_c = '0;
    cmd_pc = '0;
    pre_we = 1'b0;
    pre_idx = '0;
    pre_dat = '0;
    rr_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_sel", {29'd0, sw_sel}, 32'd0);
    chk("rst_dir", {31'd0, sw_dir}, 32'd0);
    chk("rst_load", {24'd0, reg_load}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_pc", {24'd0, rsp_pc}, 32'd0);
    chk("rst_leq", {31'd0, rsp_leq}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bus_oe", {31'd0, dut.bus_oe}, 32'd0);
    for (int i = 0; i < 8; i++) preload(3'(i), 8'($urandom));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);

    // asynchronous reset in the middle of the write cycle aborts the write
    preload(3'd1, 8'h22);
    preload(3'd3, 8'h11);
    issue(3'd1, 3'd3, 8'h55, 8'h30, 1'b0);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (reg_load != 8'h00) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("wr_b_not_reached");
    rst_n = 1'b0;
    #1;
    chk("midop_load", {24'd0, reg_load}, 32'd0);
    chk("midop_bus_oe", {31'd0, dut.bus_oe}, 32'd0);
    chk("midop_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midop_busy", {31'd0, busy}, 32'd0);
    accq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midop_ready_after_release", {31'd0, cmd_ready}, 32'd1);
    chk("midop_write_aborted", {24'd0, regs[3]}, 32'h11);

    // directed cases
    preload(3'd1, 8'h05);
    preload(3'd2, 8'h09);
    issue(3'd1, 3'd2, 8'h40, 8'h10, 1'b1);
    drain();
    preload(3'd3, 8'h07);
    preload(3'd4, 8'h07);
    issue(3'd3, 3'd4, 8'h20, 8'h00, 1'b1);
    drain();
    preload(3'd0, 8'h02);
    preload(3'd5, 8'h01);
    issue(3'd0, 3'd5, 8'h00, 8'hFE, 1'b1);
    drain();
    preload(3'd1, 8'h01);
    preload(3'd2, 8'h09);
    issue(3'd1, 3'd2, 8'h77, 8'hFE, 1'b1);
    drain();
    preload(3'd3, 8'h01);
    preload(3'd4, 8'h80);
    issue(3'd3, 3'd4, 8'h66, 8'h08, 1'b1);
    drain();
    preload(3'd6, 8'h80);
    issue(3'd6, 3'd6, 8'h44, 8'h50, 1'b1);
    drain();

    // backpressure with a competing command offered during the stall
    rr_mode = 2;
    @(posedge clk);
    preload(3'd2, 8'h30);
    preload(3'd7, 8'h10);
    issue(3'd2, 3'd7, 8'h99, 8'h21, 1'b1);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("stall_rsp_timeout");
    hold_pc = rsp_pc;
    hold_leq = rsp_leq;
    @(posedge clk);
    #1;
    cmd_a = 3'd0;
    cmd_b = 3'd1;
    cmd_c = 8'hEE;
    cmd_pc = 8'hEE;
    cmd_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_pc_stable", {24'd0, rsp_pc}, {24'd0, hold_pc});
      chk("stall_leq_stable", {31'd0, rsp_leq}, {31'd0, hold_leq});
      chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rr_mode = 0;
    drain();

    // ready held high while idle has no effect
    repeat (4) begin
      @(negedge clk);
      chk("idle_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
    end

    // randomized instruction stream with random response backpressure
    rr_mode = 1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        drain();
        preload(3'($urandom), 8'($urandom));
      end
      issue(3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    end
    drain();
    rr_mode = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++)
      chk("final_regs", {24'd0, regs[i]}, {24'd0, exp_regs[i]});
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
